// File: rtl/video_spi_checker_pkg.sv
// Shared definitions for the per-channel video SPI read-back checker:
// FSM encodings, SPI idle levels and default sizing.
package video_spi_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } spi_state_t;

    localparam logic SCK_IDLE = 1'b1;
    localparam logic CS_IDLE  = 1'b1;

    localparam int DEF_WIDTH      = 12;
    localparam int DEF_TOL        = 64;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_PAUSE      = 2;
    localparam int DEF_FAIL_LIMIT = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/video_spi_rx.sv
// Video SPI read engine: chip-select setup, WIDTH clocked bits sampled on the
// rising sckv edge (MSB first), a post-frame pause, then a one-cycle done strobe.
module video_spi_rx
    import video_spi_checker_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int PAUSE   = DEF_PAUSE
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdatav,
    output logic             sckv,
    output logic             slv,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int BW = $clog2(WIDTH + 1);

    spi_state_t       state_r;
    logic [15:0]      div_cnt_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             sckv_r;
    logic             slv_r;
    logic             busy_r;
    logic             done_r;

    // Frame sequencer, clock divider and shift register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= 16'd0;
            bit_cnt_r <= {BW{1'b0}};
            shift_r   <= {WIDTH{1'b0}};
            rx_data_r <= {WIDTH{1'b0}};
            sckv_r    <= SCK_IDLE;
            slv_r     <= CS_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r   <= ST_SETUP;
                        slv_r     <= ~CS_IDLE;
                        busy_r    <= 1'b1;
                        div_cnt_r <= 16'd0;
                        bit_cnt_r <= {BW{1'b0}};
                        shift_r   <= {WIDTH{1'b0}};
                    end
                end
                ST_SETUP: begin
                    if (div_cnt_r == 16'(CLK_DIV - 1)) begin
                        state_r   <= ST_SHIFT;
                        sckv_r    <= ~SCK_IDLE;
                        div_cnt_r <= 16'd0;
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r == 16'(CLK_DIV - 1)) begin
                        div_cnt_r <= 16'd0;
                        // Sample on the same edge that raises sckv.
                        if (sckv_r != SCK_IDLE) begin
                            sckv_r  <= SCK_IDLE;
                            shift_r <= {shift_r[WIDTH-2:0], sdatav};
                        end else if (bit_cnt_r == BW'(WIDTH - 1)) begin
                            state_r <= ST_HOLD;
                            slv_r   <= CS_IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            sckv_r    <= ~SCK_IDLE;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (div_cnt_r == 16'(PAUSE - 1)) begin
                        state_r   <= ST_CHECK;
                        done_r    <= 1'b1;
                        rx_data_r <= shift_r;
                        div_cnt_r <= 16'd0;
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                ST_CHECK: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    sckv_r  <= SCK_IDLE;
                    slv_r   <= CS_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sckv    = sckv_r;
    assign slv     = slv_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;

endmodule

// File: rtl/video_spi_checker.sv
// Per-channel BOS video read-back checker: reads one ADC sample after each DAC
// step, compares it against the expected code and tracks channel health.
module video_spi_checker
    import video_spi_checker_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int PAUSE      = DEF_PAUSE,
    parameter int TOL        = DEF_TOL,
    parameter int FAIL_LIMIT = DEF_FAIL_LIMIT
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] expected,
    input  logic             sdatav,
    output logic             sckv,
    output logic             slv,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             pass,
    output logic             led_ok,
    output logic [15:0]      err_cnt
);

    localparam int RW = $clog2(FAIL_LIMIT + 1);

    logic               accept_s;
    logic               rx_busy_s;
    logic               rx_done_s;
    logic [WIDTH-1:0]   rx_data_s;
    logic signed [WIDTH:0] diff_s;
    logic [WIDTH:0]     abs_s;
    logic               pass_s;

    logic [WIDTH-1:0]   exp_r;
    logic [WIDTH-1:0]   data_out_r;
    logic [RW-1:0]      fail_run_r;
    logic [15:0]        err_cnt_r;
    logic               busy_r;
    logic               data_valid_r;
    logic               pass_r;
    logic               led_ok_r;

    assign accept_s = start & ~busy_r & ~rx_busy_s;

    video_spi_rx #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV),
        .PAUSE   (PAUSE)
    ) u_rx (
        .sys_clk (sys_clk),
        .rst     (rst),
        .start   (accept_s),
        .sdatav  (sdatav),
        .sckv    (sckv),
        .slv     (slv),
        .busy    (rx_busy_s),
        .done    (rx_done_s),
        .rx_data (rx_data_s)
    );

    // Absolute difference in WIDTH+1 bits so full-scale codes never wrap.
    always_comb begin
        diff_s = $signed({1'b0, rx_data_s}) - $signed({1'b0, exp_r});
        if (diff_s[WIDTH]) begin
            abs_s = $unsigned(-diff_s);
        end else begin
            abs_s = $unsigned(diff_s);
        end
        pass_s = (32'(abs_s) <= 32'(TOL));
    end

    // Transaction tracking, compare result, fail run, LED and error count.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            exp_r        <= {WIDTH{1'b0}};
            data_out_r   <= {WIDTH{1'b0}};
            fail_run_r   <= {RW{1'b0}};
            err_cnt_r    <= 16'd0;
            busy_r       <= 1'b0;
            data_valid_r <= 1'b0;
            pass_r       <= 1'b0;
            led_ok_r     <= 1'b0;
        end else begin
            data_valid_r <= rx_done_s;
            if (accept_s) begin
                busy_r <= 1'b1;
                exp_r  <= expected;
            end else if (data_valid_r) begin
                busy_r <= 1'b0;
            end
            if (rx_done_s) begin
                data_out_r <= rx_data_s;
                pass_r     <= pass_s;
                if (pass_s) begin
                    fail_run_r <= {RW{1'b0}};
                    led_ok_r   <= 1'b1;
                end else begin
                    err_cnt_r <= sat_inc16(err_cnt_r);
                    if (fail_run_r != RW'(FAIL_LIMIT)) begin
                        fail_run_r <= fail_run_r + RW'(1);
                    end
                    if (fail_run_r >= RW'(FAIL_LIMIT - 1)) begin
                        led_ok_r <= 1'b0;
                    end
                end
            end else begin
                pass_r <= 1'b0;
            end
        end
    end

    assign busy       = busy_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign pass       = pass_r;
    assign led_ok     = led_ok_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_video_spi_checker.sv
// Directed bench for video_spi_checker with a behavioural BOS ADC that shifts
// out a preset word MSB first, one bit per rising sckv.
`timescale 1ns/1ps
module tb_video_spi_checker;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] expected;
    logic        sdatav;
    logic        sckv;
    logic        slv;
    logic        busy;
    logic [11:0] data_out;
    logic        data_valid;
    logic        pass;
    logic        led_ok;
    logic [15:0] err_cnt;

    logic [11:0] bos_word;
    int          total_rise = 0;
    int          rise_base = 0;
    int          slv_low_total = 0;
    int          tests = 0;
    int          fails = 0;

    int          r_lat, r_dv, r_rise, r_low;
    logic [11:0] r_data;
    logic        r_pass, r_led, r_b53, r_b54;
    logic [15:0] r_err;

    video_spi_checker dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .start      (start),
        .expected   (expected),
        .sdatav     (sdatav),
        .sckv       (sckv),
        .slv        (slv),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pass       (pass),
        .led_ok     (led_ok),
        .err_cnt    (err_cnt)
    );

    // 4 MHz system clock.
    always #125 sys_clk = ~sys_clk;

    // Count rising sckv edges inside a frame.
    always @(posedge sckv) if (!slv) total_rise <= total_rise + 1;

    // Frame start marks the bit index origin.
    always @(negedge slv) rise_base <= total_rise;

    // Count clock edges that see chip-select asserted.
    always @(posedge sys_clk) if (!slv) slv_low_total <= slv_low_total + 1;

    // BOS data output: bit presented until the rising sckv that consumes it.
    always_comb begin
        int idx;
        idx = total_rise - rise_base;
        if (idx >= 0 && idx < 12) sdatav = bos_word[11 - idx];
        else sdatav = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [11:0] e, input logic [11:0] w, input bit pulses);
        int rise0, low0;
        bos_word = w;
        @(negedge sys_clk);
        expected = e;
        start    = 1'b1;
        rise0    = total_rise;
        low0     = slv_low_total;
        @(posedge sys_clk); #1;
        r_lat = 0; r_dv = 0; r_b53 = 1'b0; r_b54 = 1'b1;
        r_data = 12'h000; r_pass = 1'b0; r_led = 1'b0; r_err = 16'h0000;
        for (int n = 1; n <= 70; n++) begin
            @(negedge sys_clk);
            start    = pulses && (n == 5 || n == 52);
            expected = ~e;
            @(posedge sys_clk); #1;
            if (data_valid) begin
                r_dv++;
                if (r_lat == 0) begin
                    r_lat = n; r_data = data_out; r_pass = pass; r_led = led_ok; r_err = err_cnt;
                end
            end
            if (n == 53) r_b53 = busy;
            if (n == 54) r_b54 = busy;
        end
        start  = 1'b0;
        r_rise = total_rise - rise0;
        r_low  = slv_low_total - low0;
    endtask

    logic [11:0] tol_w [4] = '{12'h840, 12'h7C0, 12'h841, 12'h7BF};
    logic        tol_p [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] tol_e [4] = '{16'd0, 16'd0, 16'd1, 16'd2};

    initial begin
        int rise0;
        rst = 1'b1; start = 1'b0; expected = 12'h000; bos_word = 12'h000;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_sckv", sckv, 1'b1);
        check("rst_slv", slv, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_dv", data_valid, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_led", led_ok, 1'b0);
        check("rst_data", data_out, 12'h000);
        check("rst_err", err_cnt, 16'd0);
        @(negedge sys_clk);
        rst = 1'b0;

        run_txn(12'h800, 12'h800, 1'b0);
        check("basic_lat", r_lat, 53);
        check("basic_data", r_data, 12'h800);
        check("basic_pass", r_pass, 1'b1);
        check("basic_led", r_led, 1'b1);
        check("basic_err", r_err, 16'd0);
        check("basic_rises", r_rise, 12);
        check("basic_slv_low", r_low, 50);
        check("basic_dv_cnt", r_dv, 1);
        check("basic_busy_check", r_b53, 1'b1);
        check("basic_busy_after", r_b54, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_txn(12'h800, tol_w[i], 1'b0);
            check("tol_data", r_data, tol_w[i]);
            check("tol_pass", r_pass, tol_p[i]);
            check("tol_err", r_err, tol_e[i]);
            check("tol_led", r_led, 1'b1);
        end

        run_txn(12'hA00, 12'hA00, 1'b0);
        check("run_pre_pass", r_pass, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_txn(12'hFFF, 12'h000, 1'b0);
            check("run_pass", r_pass, 1'b0);
            check("run_err", r_err, 16'(3 + i));
            check("run_led", r_led, (i < 3) ? 1'b1 : 1'b0);
        end
        run_txn(12'h555, 12'h555, 1'b0);
        check("run_recover_pass", r_pass, 1'b1);
        check("run_recover_led", r_led, 1'b1);
        check("run_recover_err", r_err, 16'd6);

        run_txn(12'h000, 12'hFFF, 1'b0);
        check("ext_low_pass", r_pass, 1'b0);
        check("ext_low_err", r_err, 16'd7);
        run_txn(12'hFFF, 12'hFC0, 1'b0);
        check("ext_high_pass", r_pass, 1'b1);
        check("ext_high_data", r_data, 12'hFC0);

        run_txn(12'h300, 12'h300, 1'b1);
        check("busy_dv_cnt", r_dv, 1);
        check("busy_lat", r_lat, 53);
        check("busy_pass", r_pass, 1'b1);
        run_txn(12'h300, 12'h310, 1'b0);
        check("busy_next_lat", r_lat, 53);
        check("busy_next_pass", r_pass, 1'b1);
        check("busy_next_dv_cnt", r_dv, 1);

        bos_word = 12'hABC;
        @(negedge sys_clk);
        expected = 12'hABC; start = 1'b1; rise0 = total_rise;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (27) @(negedge sys_clk);
        check("mid_pre_sckv", sckv, 1'b0);
        check("mid_pre_slv", slv, 1'b0);
        check("mid_pre_rises", total_rise - rise0, 6);
        rst = 1'b1;
        #1;
        check("mid_rst_slv", slv, 1'b1);
        check("mid_rst_sckv", sckv, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        check("mid_rst_dv", data_valid, 1'b0);
        check("mid_rst_err", err_cnt, 16'd0);
        check("mid_rst_led", led_ok, 1'b0);
        check("mid_rst_data", data_out, 12'h000);
        @(negedge sys_clk);
        rst = 1'b0;

        run_txn(12'h123, 12'h123, 1'b0);
        check("post_lat", r_lat, 53);
        check("post_data", r_data, 12'h123);
        check("post_pass", r_pass, 1'b1);
        check("post_led", r_led, 1'b1);
        check("post_err", r_err, 16'd0);
        check("post_rises", r_rise, 12);
        check("post_slv_low", r_low, 50);
        check("post_dv_cnt", r_dv, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
